pc_sched: RTL
=============

# pc_sched

Next-PC scheduler and stall controller for the 5-stage MIPS pipeline. It sits beside the PC register and the IF/ID, ID/EX pipeline registers. Each cycle it selects the next fetch address and drives the PC write enable and the pipeline enable/clear lines. It arbitrates exception/eret redirects, load-use and mult/div stalls, and D-stage branch/jump redirects, and owns the mult/div busy counter.

## Interface
Parameters:
- EXC_VEC, 32'h0000_4180, exception handler entry address
- BOOT_PC, 32'h0000_3000, npc_out value while reset is asserted
- MULT_CYC, 5, busy cycles for mult/multu
- DIV_CYC, 10, busy cycles for div/divu

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- pc_F  in  32  current PC register value
- br_taken_D  in  1  D-stage branch/jump resolved taken
- br_target_D  in  32  D-stage redirect target
- ld_use_D  in  1  load-use hazard detected in D
- md_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- md_start_E  in  1  mult/div instruction valid in E this cycle
- md_div_E  in  1  qualifies md_start_E: 1 = div, 0 = mult
- exc_req  in  1  exception taken in M
- eret_req  in  1  eret committing in M
- epc  in  32  return address for eret
- npc_out  out  32  next PC, to the PC NPc input
- pc_en  out  1  PC write enable
- fd_en  out  1  IF/ID register enable
- de_clr  out  1  ID/EX insert bubble
- flush  out  1  flush IF/ID, ID/EX, EX/MEM
- md_busy  out  1  mult/div unit busy

## Operation
- State: mode ∈ {IDLE, MULT, DIV}; 4-bit count.
- IDLE:
  - If md_start_E & !md_div_E: go to MULT, count = MULT_CYC.
  - If md_start_E & md_div_E: go to DIV, count = DIV_CYC.
- MULT/DIV: count decrements each cycle. On the cycle count == 1, the next state is IDLE with count = 0.
  - md_start_E while not IDLE is ignored. The stall makes this case unreachable; an assertion checks it.
- md_busy = (mode != IDLE). The output is registered.
- stall = ld_use_D | (md_use_D & (md_busy | md_start_E)).
- Outputs are combinational, with strict priority (highest first):
  1. exc_req: npc_out = EXC_VEC; pc_en = 1; flush = 1; fd_en = 1; de_clr = 0.
  2. eret_req: npc_out = epc; pc_en = 1; flush = 1. If exc_req and eret_req are both high, exc_req wins.
  3. stall: pc_en = 0; fd_en = 0; de_clr = 1; npc_out = pc_F + 4. br_taken_D is ignored, because the branch is re-resolved after the stall.
  4. br_taken_D: npc_out = br_target_D; pc_en = 1; fd_en = 1.
  5. Otherwise: npc_out = pc_F + 4, wrapping mod 2^32; pc_en = 1; fd_en = 1.
- Defaults unless set above: flush = 0, de_clr = 0.
- flush and exception redirects do not abort the mult/div counter. The unit runs to completion.

## Timing
- While reset is low: mode = IDLE, count = 0, md_busy = 0, pc_en = 0, fd_en = 0, de_clr = 1, flush = 1, npc_out = BOOT_PC.
- Reset asserted mid mult/div returns the block to IDLE immediately (asynchronous).
- Redirect latency:
  - npc_out is valid in the same cycle as its inputs (0-cycle combinational).
  - The PC loads the new value at the next posedge.
- md_busy rises on the cycle after the md_start_E edge and stays high for exactly MULT_CYC or DIV_CYC cycles.
- When md_start_E and md_use_D are both high in the same cycle, the stall applies in that cycle too.
- When the counter falls to 0, the stalled md_use_D instruction advances on the next edge. Total stall length: MULT_CYC + 1 cycles for mult, DIV_CYC + 1 cycles for div.

## Test plan
- Reset low for 2 cycles, then release with pc_F = 0x3000 → during reset npc_out = 0x3000 and pc_en = 0; after release npc_out = 0x3004, pc_en = 1, md_busy = 0.
- ld_use_D = 1 for 1 cycle with br_taken_D = 1 and br_target_D = 0x3100 → pc_en = 0, fd_en = 0, de_clr = 1, and npc_out ≠ 0x3100 that cycle.
- md_start_E & md_div_E at cycle t, md_use_D held high → pc_en = 0 for cycles t..t+10, md_busy high for t+1..t+10, pc_en = 1 at t+11.
- exc_req and eret_req together with epc = 0x3020 → npc_out = 0x0000_4180, flush = 1, pc_en = 1.
- eret_req with epc = 0x3020 during an active mult → npc_out = 0x3020, flush = 1, and md_busy continues until the count expires.
- pc_F = 0xFFFF_FFFC, no events → npc_out = 0x0000_0000.

Source files
------------

// File: rtl/pc_sched.sv
// rtl/pc_sched.sv - next-PC select, pipeline stall/flush control and mult/div busy counter
module pc_sched #(
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
    parameter logic [31:0] BOOT_PC  = 32'h0000_3000,
    parameter int          MULT_CYC = 5,
    parameter int          DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_F,
    input  logic        br_taken_D,
    input  logic [31:0] br_target_D,
    input  logic        ld_use_D,
    input  logic        md_use_D,
    input  logic        md_start_E,
    input  logic        md_div_E,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] npc_out,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_clr,
    output logic        flush,
    output logic        md_busy
);

    typedef enum logic [1:0] {IDLE, MULT, DIV} mode_t;

    mode_t       mode;
    logic [3:0]  count;
    logic        stall;
    logic [31:0] pc_plus4;

    // Flush/exception redirects deliberately do not touch the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode    <= IDLE;
            count   <= 4'd0;
            md_busy <= 1'b0;
        end else begin
            case (mode)
                IDLE: begin
                    if (md_start_E) begin
                        mode    <= md_div_E ? DIV : MULT;
                        count   <= md_div_E ? 4'(DIV_CYC) : 4'(MULT_CYC);
                        md_busy <= 1'b1;
                    end
                end
                MULT, DIV: begin
                    if (count == 4'd1) begin
                        mode    <= IDLE;
                        count   <= 4'd0;
                        md_busy <= 1'b0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    mode    <= IDLE;
                    count   <= 4'd0;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

    assign pc_plus4 = pc_F + 32'd4;
    // The starting mult/div already stalls a dependent D instruction in its issue cycle.
    assign stall    = ld_use_D | (md_use_D & (md_busy | md_start_E));

    always_comb begin
        npc_out = pc_plus4;
        pc_en   = 1'b1;
        fd_en   = 1'b1;
        de_clr  = 1'b0;
        flush   = 1'b0;
        if (!reset) begin
            npc_out = BOOT_PC;
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            de_clr  = 1'b1;
            flush   = 1'b1;
        end else if (exc_req) begin
            npc_out = EXC_VEC;
            flush   = 1'b1;
        end else if (eret_req) begin
            npc_out = epc;
            flush   = 1'b1;
        end else if (stall) begin
            pc_en   = 1'b0;
            fd_en   = 1'b0;
            de_clr  = 1'b1;
        end else if (br_taken_D) begin
            npc_out = br_target_D;
        end
    end

    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (!reset) !(md_start_E && (mode != IDLE))
    );

endmodule
